// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the comm-domain nonce path.
//   NONCE_W      : width of a golden nonce word.
//   arb_state_e  : TX sequencer states (IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3).
//   clog2()      : ceiling log2, used to size pointers and counters.
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nonce_arbiter_if.sv
// ---------------------------------------------------------------------------
// nonce_arbiter_if
// Bundles the core-facing request bus, the serial TX handshake and the
// status/debug outputs of nonce_arbiter.
//
// Handshakes:
//   Core side  : a core raises slave_valid[i] with its nonce and holds both
//                until it sees slave_ack[i] high; the nonce is taken at the
//                rising edge that ends the ack cycle, and the core must drop
//                or replace the request in the following cycle.
//   Serial side: serial_send is a one-cycle request with word stable; the
//                serial core answers by raising serial_busy while it
//                transmits and lowering it when done.
//
// Modports:
//   master : the environment (hashing cores, serial core, job loader).
//   slave  : the arbiter itself.
// ---------------------------------------------------------------------------
interface nonce_arbiter_if
    import miner_pkg::*;
#(
    parameter int SLAVES     = 4,
    parameter int FIFO_DEPTH = 8
) ();

    localparam int CW = clog2(FIFO_DEPTH) + 1;

    logic [SLAVES-1:0]         slave_valid;
    logic [NONCE_W*SLAVES-1:0] slave_nonces;
    logic [SLAVES-1:0]         slave_ack;
    logic                      flush;
    logic [NONCE_W-1:0]        word;
    logic                      serial_send;
    logic                      serial_busy;
    logic                      new_nonce;
    logic [CW-1:0]             fifo_count;
    arb_state_e                dbg_state;

    modport master (
        output slave_valid, slave_nonces, flush, serial_busy,
        input  slave_ack, word, serial_send, new_nonce, fifo_count, dbg_state
    );

    modport slave (
        input  slave_valid, slave_nonces, flush, serial_busy,
        output slave_ack, word, serial_send, new_nonce, fifo_count, dbg_state
    );

endinterface

// File: rtl/nonce_fifo.sv
// ---------------------------------------------------------------------------
// nonce_fifo
// Synchronous FIFO for accepted nonces. Pointers carry one extra MSB so
// that full and empty are told apart without a separate counter.
//   clk, rst_n : clock, synchronous active-low reset.
//   push, din  : write request and data (ignored when full or flushing).
//   pop        : read request; dout shows the head before the pop.
//   flush      : empties the queue at the edge; overrides push and pop.
//   full, empty, count : occupancy status.
// ---------------------------------------------------------------------------
module nonce_fifo
    import miner_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = NONCE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    input  logic                          flush,
    output logic                          full,
    output logic                          empty,
    output logic [clog2(DEPTH):0]         count,
    output logic [WIDTH-1:0]              dout
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Same index bits but different wrap bit means the writer lapped the reader.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/nonce_arbiter.sv
// ---------------------------------------------------------------------------
// nonce_arbiter
// Round-robin collector for golden nonces from SLAVES hashing cores. Accepted
// nonces are queued in nonce_fifo and handed to the serial core one word at
// a time under a send/busy handshake, with a timeout in case the serial core
// never answers.
//   clk   : comm clock, rising edge.
//   rst_n : synchronous active-low reset.
//   bus   : nonce_arbiter_if.slave -- core requests/acks, flush, serial
//           handshake (word, serial_send, serial_busy), new_nonce pulse,
//           fifo_count and the sequencer state on dbg_state.
// ---------------------------------------------------------------------------
module nonce_arbiter
    import miner_pkg::*;
#(
    parameter int SLAVES       = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    nonce_arbiter_if.slave bus
);

    localparam int PW = (SLAVES > 1) ? clog2(SLAVES) : 1;
    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam int TW = clog2(BUSY_TIMEOUT) + 1;

    arb_state_e          state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [NONCE_W-1:0]  word_q, word_d;
    logic                new_nonce_q, new_nonce_d;

    logic                grant_any;
    int                  win;
    logic [SLAVES-1:0]   ack;
    logic [NONCE_W-1:0]  grant_nonce;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [CW-1:0]       fifo_count;
    logic [NONCE_W-1:0]  fifo_dout;

    // -----------------------------------------------------------------------
    // Arbitration: scan from rr_ptr upward with wrap, first valid wins.
    // Full is the registered state, so a pop in this cycle never frees a
    // slot for a push in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        int idx;
        idx         = 0;
        grant_any   = 1'b0;
        win         = 0;
        ack         = '0;
        grant_nonce = '0;
        if (!fifo_full && !bus.flush) begin
            for (int k = 0; k < SLAVES; k++) begin
                idx = (int'(rr_ptr_q) + k) % SLAVES;
                if (!grant_any && bus.slave_valid[idx]) begin
                    grant_any = 1'b1;
                    win       = idx;
                end
            end
        end
        if (grant_any) begin
            ack[win]    = 1'b1;
            grant_nonce = bus.slave_nonces[NONCE_W*win +: NONCE_W];
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        new_nonce_d = grant_any;
        if (grant_any) begin
            rr_ptr_d = (win == SLAVES - 1) ? '0 : PW'(win + 1);
        end
    end

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NONCE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant_any),
        .din   (grant_nonce),
        .pop   (fifo_pop),
        .flush (bus.flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .dout  (fifo_dout)
    );

    // -----------------------------------------------------------------------
    // TX sequencer. A flush only blocks a new pop; a word already taken
    // from the queue runs through SEND/WAIT_* to completion.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        word_d    = word_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.flush) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_dout;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.serial_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    // Serial core never picked the word up; drop it.
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.serial_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            word_q      <= '0;
            new_nonce_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            word_q      <= word_d;
            new_nonce_q <= new_nonce_d;
        end
    end

    assign bus.slave_ack   = ack;
    assign bus.word        = word_q;
    assign bus.serial_send = (state_q == SEND);
    assign bus.new_nonce   = new_nonce_q;
    assign bus.fifo_count  = fifo_count;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nonce_arbiter
// Bench for nonce_arbiter: directed scenarios plus a randomized run, all
// scored against a queue-based model of the nonce path.
// ---------------------------------------------------------------------------
module tb_nonce_arbiter;
    import miner_pkg::*;

    localparam int SLAVES  = 4;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int PEND    = 256;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    nonce_arbiter_if #(.SLAVES(SLAVES), .FIFO_DEPTH(DEPTH)) bus ();

    nonce_arbiter #(
        .SLAVES       (SLAVES),
        .FIFO_DEPTH   (DEPTH),
        .BUSY_TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- core and serial-core drivers ----------------
    logic [31:0]       pend_mem [SLAVES][PEND];
    int                pend_wr [SLAVES] = '{default: 0};
    int                pend_rd [SLAVES] = '{default: 0};
    logic [SLAVES-1:0] ack_seen  = '0;
    logic              send_seen = 1'b0;
    logic              busy_auto   = 1'b0;
    logic              busy_manual = 1'b0;
    int                busy_dly = 0;
    int                busy_len = 0;

    task automatic enq(input int s, input logic [31:0] v);
        pend_mem[s][pend_wr[s] % PEND] = v;
        pend_wr[s]++;
    endtask

    function automatic bit pend_idle();
        for (int i = 0; i < SLAVES; i++) begin
            if (pend_rd[i] != pend_wr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Each core holds its head nonce until acked, then moves to the next.
    // The serial core in auto mode answers each send after 0..3 cycles and
    // stays busy for 1..8 cycles.
    always @(posedge clk) begin
        logic [SLAVES-1:0]    v;
        logic [32*SLAVES-1:0] n;
        #1;
        v = '0;
        n = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (ack_seen[i] && pend_rd[i] != pend_wr[i]) pend_rd[i]++;
            if (pend_rd[i] != pend_wr[i]) begin
                v[i] = 1'b1;
                n[32*i +: 32] = pend_mem[i][pend_rd[i] % PEND];
            end
        end
        bus.slave_valid  = v;
        bus.slave_nonces = n;
        if (busy_auto) begin
            if (send_seen) begin
                busy_dly = $urandom_range(0, 3);
                busy_len = $urandom_range(1, 8);
            end
            if (busy_dly > 0) begin
                busy_dly--;
                bus.serial_busy = 1'b0;
            end else if (busy_len > 0) begin
                busy_len--;
                bus.serial_busy = 1'b1;
            end else begin
                bus.serial_busy = 1'b0;
            end
        end else begin
            bus.serial_busy = busy_manual;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    // The queue holds what the FIFO should contain; events seen in one cycle
    // take effect on the model at the start of the next.
    logic [31:0] exp_q[$];
    int          rr_model  = 0;
    int          cyc       = 0;
    int          last_send = -100;
    logic        prev_push  = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_val   = '0;
    logic [31:0] last_word  = '0;

    always @(negedge clk) begin
        logic [SLAVES-1:0] exp_ack;
        int                w;
        if (!rst_n) begin
            exp_q.delete();
            rr_model   = 0;
            prev_push  = 1'b0;
            prev_flush = 1'b0;
            prev_val   = '0;
            last_word  = '0;
            last_send  = cyc - 100;
            ack_seen   = '0;
            send_seen  = 1'b0;
        end else begin
            cyc++;
            if (prev_flush) exp_q.delete();
            else if (prev_push) exp_q.push_back(prev_val);

            check("new_nonce", bus.new_nonce, prev_push);

            if (bus.serial_send) begin
                check("send_spacing", (cyc - last_send) >= 4, 1);
                check("send_has_data", exp_q.size() > 0, 1);
                last_send = cyc;
                if (exp_q.size() > 0) last_word = exp_q.pop_front();
            end
            check("word", bus.word, last_word);
            check("fifo_count", bus.fifo_count, exp_q.size());

            exp_ack = '0;
            w = -1;
            if (!bus.flush && exp_q.size() < DEPTH) begin
                for (int k = 0; k < SLAVES; k++) begin
                    if (w < 0 && bus.slave_valid[(rr_model + k) % SLAVES]) w = (rr_model + k) % SLAVES;
                end
            end
            if (w >= 0) begin
                exp_ack[w] = 1'b1;
                rr_model   = (w + 1) % SLAVES;
                prev_val   = bus.slave_nonces[32*w +: 32];
            end
            check("slave_ack", bus.slave_ack, exp_ack);
            prev_push  = (w >= 0);
            prev_flush = bus.flush;
            ack_seen   = bus.slave_ack;
            send_seen  = bus.serial_send;
        end
    end

    // ---------------- scenarios ----------------
    task automatic drain();
        int guard;
        guard = 0;
        busy_auto = 1'b1;
        while (!(pend_idle() && bus.fifo_count == 0 && bus.dbg_state == IDLE) && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_done", guard < 10000, 1);
    endtask

    task automatic wait_send(input string tag, input int limit);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.serial_send && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        check(tag, bus.serial_send, 1);
    endtask

    initial begin
        int order [8];
        int got;
        int guard;
        int sends;
        int s;

        rst_n    = 1'b0;
        bus.flush = 1'b0;

        // Reset and single push from core 2.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ack", bus.slave_ack, 0);
        check("rst_send", bus.serial_send, 0);
        check("rst_new", bus.new_nonce, 0);
        check("rst_word", bus.word, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_state", bus.dbg_state, IDLE);
        enq(2, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_ack", bus.slave_ack, 4'b0100);
        @(negedge clk);
        check("t1_new", bus.new_nonce, 1);
        @(negedge clk);
        check("t1_send", bus.serial_send, 1);
        check("t1_word", bus.word, 32'hDEADBEEF);
        busy_manual = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_wait_done", bus.dbg_state, WAIT_DONE);
        busy_manual = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t1_idle", bus.dbg_state, IDLE);

        // Round robin, all cores busy, serial core silent. Core 2 won last,
        // so the scan starts at core 3.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < SLAVES; i++) enq(i, 32'h10 + i + (k << 8));
        end
        got = 0;
        guard = 0;
        while (got < 8 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus.slave_ack != 0) begin
                for (int i = 0; i < SLAVES; i++) if (bus.slave_ack[i]) order[got] = i;
                got++;
            end
        end
        check("rr_acks", got, 8);
        for (int j = 0; j < 8; j++) check("rr_order", order[j], (3 + j) % SLAVES);
        repeat (5) @(negedge clk);
        check("rr_full", bus.fifo_count, DEPTH);
        drain();

        // Full stall: serial core stuck busy, queue full, then core 1 asks.
        busy_auto   = 1'b0;
        busy_manual = 1'b1;
        for (int k = 0; k < 9; k++) enq(0, 32'hA000_0000 + k);
        guard = 0;
        while (!(bus.fifo_count == DEPTH && pend_idle()) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("full_reached", bus.fifo_count, DEPTH);
        enq(1, 32'hB0B0_0001);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("full_no_ack", bus.slave_ack, 0);
        end
        busy_manual = 1'b0;
        wait_send("full_send", 20);
        check("full_late_ack", bus.slave_ack, 4'b0010);
        drain();

        // Flush while a word is in flight.
        busy_auto   = 1'b0;
        busy_manual = 1'b1;
        for (int k = 0; k < 3; k++) begin
            enq(3, 32'hF300_0000 + k);
            enq(1, 32'hF100_0000 + k);
        end
        guard = 0;
        while (!(bus.fifo_count == 5 && pend_idle() && bus.dbg_state == WAIT_DONE) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("flush_setup", bus.fifo_count, 5);
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_count", bus.fifo_count, 0);
        check("flush_inflight", bus.dbg_state, WAIT_DONE);
        busy_manual = 1'b0;
        sends = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.serial_send) sends++;
        end
        check("flush_no_send", sends, 0);
        check("flush_idle", bus.dbg_state, IDLE);
        enq(0, 32'h5EED_0001);
        wait_send("flush_resend", 20);
        check("flush_word", bus.word, 32'h5EED_0001);
        drain();

        // Timeout: serial_busy never rises.
        busy_auto   = 1'b0;
        busy_manual = 1'b0;
        enq(2, 32'h7100_0001);
        enq(2, 32'h7100_0002);
        wait_send("tmo_first", 20);
        for (int j = 1; j <= TIMEOUT; j++) begin
            @(negedge clk);
            if (j == 1 || j == TIMEOUT) check("tmo_wait_busy", bus.dbg_state, WAIT_BUSY);
        end
        @(negedge clk);
        check("tmo_idle", bus.dbg_state, IDLE);
        @(negedge clk);
        check("tmo_next_send", bus.serial_send, 1);
        check("tmo_next_word", bus.word, 32'h7100_0002);
        drain();

        // Push and pop in the same cycle with three queued.
        busy_auto   = 1'b0;
        busy_manual = 1'b1;
        for (int k = 0; k < 4; k++) enq(0, 32'hC000_0000 + k);
        guard = 0;
        while (!(bus.fifo_count == 3 && pend_idle() && bus.dbg_state == WAIT_DONE) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("pp_setup", bus.fifo_count, 3);
        busy_manual = 1'b0;
        @(negedge clk);
        enq(2, 32'hCAFE_0003);
        @(negedge clk);
        check("pp_ack", bus.slave_ack, 4'b0100);
        check("pp_idle", bus.dbg_state, IDLE);
        check("pp_count_before", bus.fifo_count, 3);
        @(negedge clk);
        check("pp_count_after", bus.fifo_count, 3);
        check("pp_send", bus.serial_send, 1);
        drain();
        check("pp_last_word", bus.word, 32'hCAFE_0003);

        // Randomized traffic with occasional flushes and one mid-run reset.
        busy_auto = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            rst_n     = !(c == 700 || c == 701);
            bus.flush = rst_n && ($urandom_range(0, 79) == 0);
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, SLAVES - 1);
                if (pend_wr[s] - pend_rd[s] < 100) enq(s, $urandom);
            end
        end
        @(posedge clk);
        #1 bus.flush = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
